mat_stream_loader: RTL

//  Upstream stage of the matrix-multiply accelerator. Accepts one matrix (SIZE words, row-major)

---
 rtl/mat_stream_loader.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/mat_stream_loader.sv
// ---------------------------------------------------------------------------
// mat_stream_loader
//   Upstream stage of the matrix-multiply accelerator. Receives one matrix
//   (SIZE words, row-major) over AXI-Stream and writes it word by word into
//   the A or B matrix BRAM. The frame length is checked against tlast, and
//   completion or error is reported to the AXI-Lite control path.
//
//   Optional build macro: MAT_LOADER_TRANSPOSE_EN
//     defined     : B (latched sel=1) is stored column-major,
//                   wr_addr = (count%DIM)*DIM + count/DIM
//     not defined : wr_addr = count for both matrices
//
// Ports
//   s00_axi_aclk     clock, rising edge
//   s00_axi_aresetn  asynchronous active-low reset
//   start            one-cycle pulse, begin loading one matrix
//   sel              target matrix (0 = A, 1 = B), sampled on start
//   s00_axis_tready  slave ready (registered)
//   s00_axis_tdata   slave data
//   s00_axis_tlast   slave end-of-frame
//   s00_axis_tvalid  slave valid
//   wr_en_A/wr_en_B  one-cycle BRAM write strobes
//   wr_addr/wr_data  shared BRAM write address/data
//   busy             high while receiving or draining
//   done             one-cycle pulse at end of a load
//   err_tlast        sticky frame-length mismatch flag for the last load
// ---------------------------------------------------------------------------
module mat_stream_loader #(
   parameter int DIM_LOG    = 1,
   parameter int DIM        = 2**DIM_LOG,
   parameter int SIZE       = DIM*DIM,
   parameter int SIZE_LOG   = 2*DIM_LOG,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  s00_axi_aclk,
   input  logic                  s00_axi_aresetn,
   input  logic                  start,
   input  logic                  sel,
   output logic                  s00_axis_tready,
   input  logic [DATA_WIDTH-1:0] s00_axis_tdata,
   input  logic                  s00_axis_tlast,
   input  logic                  s00_axis_tvalid,
   output logic                  wr_en_A,
   output logic                  wr_en_B,
   output logic [SIZE_LOG-1:0]   wr_addr,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  busy,
   output logic                  done,
   output logic                  err_tlast
);

   typedef enum logic [1:0] {
      IDLE,
      RECV,
      DRAIN,
      DONE
   } state_t;

   state_t              state;
   logic [SIZE_LOG:0]   count;
   logic                sel_q;
   logic                hs;
   logic                at_last;
   logic [SIZE_LOG-1:0] addr_nxt;

   assign hs      = s00_axis_tvalid & s00_axis_tready;
   assign at_last = (count == (SIZE_LOG+1)'(SIZE-1));

`ifdef MAT_LOADER_TRANSPOSE_EN
   // Swapping the row and column halves of count gives (count%DIM)*DIM + count/DIM.
   assign addr_nxt = sel_q ? {count[DIM_LOG-1:0], count[SIZE_LOG-1:DIM_LOG]}
                           : count[SIZE_LOG-1:0];
`else
   assign addr_nxt = count[SIZE_LOG-1:0];
`endif

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         state           <= IDLE;
         count           <= '0;
         sel_q           <= 1'b0;
         s00_axis_tready <= 1'b0;
         wr_en_A         <= 1'b0;
         wr_en_B         <= 1'b0;
         wr_addr         <= '0;
         wr_data         <= '0;
         busy            <= 1'b0;
         done            <= 1'b0;
         err_tlast       <= 1'b0;
      end else begin
         wr_en_A <= 1'b0;
         wr_en_B <= 1'b0;
         done    <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  sel_q           <= sel;
                  count           <= '0;
                  err_tlast       <= 1'b0;
                  s00_axis_tready <= 1'b1;
                  busy            <= 1'b1;
                  state           <= RECV;
               end
            end
            RECV: begin
               if (hs) begin
                  wr_en_A <= ~sel_q;
                  wr_en_B <= sel_q;
                  wr_addr <= addr_nxt;
                  wr_data <= s00_axis_tdata;
                  count   <= count + 1'b1;
                  if (at_last && !s00_axis_tlast) begin
                     // Long frame: keep tready high and discard the excess.
                     err_tlast <= 1'b1;
                     state     <= DRAIN;
                  end else if (at_last || s00_axis_tlast) begin
                     err_tlast       <= ~at_last;
                     s00_axis_tready <= 1'b0;
                     busy            <= 1'b0;
                     done            <= 1'b1;
                     state           <= DONE;
                  end
               end
            end
            DRAIN: begin
               if (hs && s00_axis_tlast) begin
                  s00_axis_tready <= 1'b0;
                  busy            <= 1'b0;
                  done            <= 1'b1;
                  state           <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               s00_axis_tready <= 1'b0;
               busy            <= 1'b0;
               state           <= IDLE;
            end
         endcase
      end
   end

endmodule
